// File: rtl/full_tap_arb_if.sv
// Stage-side request/grant handshakes and tap-memory port of the tap arbiter.
// The slave modport is the arbiter's view; master is the surrounding stage plus memory.
interface full_tap_arb_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 192
) ();
  logic              reload;
  logic              ld_req;
  logic [DATA_W-1:0] ld_data;
  logic              ld_gnt;
  logic              fwd_req;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_gnt;
  logic              fwd_rd_vld;
  logic [DATA_W-1:0] fwd_rd_data;
  logic              upd_req;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_data;
  logic              upd_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              load_done;
  logic              running;

  modport slave (
    input  reload, ld_req, ld_data, fwd_req, fwd_addr, upd_req, upd_addr, upd_data,
           mem_rd_data,
    output ld_gnt, fwd_gnt, fwd_rd_vld, fwd_rd_data, upd_gnt,
           mem_en, mem_we, mem_addr, mem_wr_data, load_done, running
  );

  modport master (
    output reload, ld_req, ld_data, fwd_req, fwd_addr, upd_req, upd_addr, upd_data,
           mem_rd_data,
    input  ld_gnt, fwd_gnt, fwd_rd_vld, fwd_rd_data, upd_gnt,
           mem_en, mem_we, mem_addr, mem_wr_data, load_done, running
  );
endinterface

// File: rtl/full_tap_arb.sv
// Tap RAM port owner: sequential tap load phase, then round-robin sharing of the
// single port between forward-pass reads and weight-update writes.
module full_tap_arb #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 192,
  parameter int unsigned RD_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  full_tap_arb_if.slave bus
);
  localparam int unsigned VLD_W = RD_LAT + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_LOAD, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic              rr_upd_q, rr_upd_d;   // last fwd/upd grant went to upd
  logic              load_done_q, load_done_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [VLD_W-1:0]  vld_sr_q, vld_sr_d;
  logic              ld_gnt_c, fwd_gnt_c, upd_gnt_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_LOAD;
      ld_cnt_q      <= '0;
      rr_upd_q      <= 1'b1;
      load_done_q   <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      vld_sr_q      <= '0;
    end else begin
      state_q       <= state_d;
      ld_cnt_q      <= ld_cnt_d;
      rr_upd_q      <= rr_upd_d;
      load_done_q   <= load_done_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      vld_sr_q      <= vld_sr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    rr_upd_d      = rr_upd_q;
    load_done_d   = 1'b0;
    ld_gnt_c      = 1'b0;
    fwd_gnt_c     = 1'b0;
    upd_gnt_c     = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;

    unique case (state_q)
      ST_LOAD: begin
        ld_gnt_c = bus.ld_req;
        if (ld_gnt_c) begin
          if (ld_cnt_q == LAST_ADDR) begin
            state_d     = ST_RUN;
            ld_cnt_d    = '0;
            load_done_d = 1'b1;
          end else begin
            ld_cnt_d = ld_cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        // Under contention the requester not granted most recently wins.
        if (bus.fwd_req && bus.upd_req) begin
          fwd_gnt_c = rr_upd_q;
          upd_gnt_c = !rr_upd_q;
        end else begin
          fwd_gnt_c = bus.fwd_req;
          upd_gnt_c = bus.upd_req;
        end
        if (fwd_gnt_c) rr_upd_d = 1'b0;
        if (upd_gnt_c) rr_upd_d = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase

    // Reload overrides any transition, including a coincident final load grant.
    if (bus.reload) begin
      state_d     = ST_LOAD;
      ld_cnt_d    = '0;
      load_done_d = 1'b0;
    end

    mem_en_d = ld_gnt_c || fwd_gnt_c || upd_gnt_c;
    mem_we_d = ld_gnt_c || upd_gnt_c;
    if (ld_gnt_c) begin
      mem_addr_d    = ld_cnt_q;
      mem_wr_data_d = bus.ld_data;
    end else if (upd_gnt_c) begin
      mem_addr_d    = bus.upd_addr;
      mem_wr_data_d = bus.upd_data;
    end else if (fwd_gnt_c) begin
      mem_addr_d    = bus.fwd_addr;
    end

    vld_sr_d = {vld_sr_q[VLD_W-2:0], fwd_gnt_c};
  end

  assign bus.ld_gnt      = ld_gnt_c;
  assign bus.fwd_gnt     = fwd_gnt_c;
  assign bus.upd_gnt     = upd_gnt_c;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.fwd_rd_vld  = vld_sr_q[VLD_W-1];
  assign bus.fwd_rd_data = bus.mem_rd_data;
  assign bus.load_done   = load_done_q;
  assign bus.running     = (state_q == ST_RUN);
endmodule

// File: tb/tb_full_tap_arb.sv
// Bench for full_tap_arb: directed scenarios plus random traffic against a
// transaction-level model (phase flag, load count, expected-return queue).
module tb_full_tap_arb;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 192;
  localparam int unsigned RD_LAT = 2;

  logic clk;
  logic reset;
  full_tap_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  full_tap_arb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tap memory with RD_LAT-cycle registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wr_data;
    rd_pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rd_data = rd_pipe[RD_LAT-1];

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int                cyc;
  bit                m_run;
  int                m_cnt;
  bit                m_rr_upd;
  logic [DATA_W-1:0] shadow [DEPTH];
  bit                exp_en, exp_we, exp_done;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;
  int                rq_cyc [$];
  logic [DATA_W-1:0] rq_data [$];
  bit                g_ld, g_fwd, g_upd;

  function automatic logic [DATA_W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_rr_upd = 1;
    exp_en = 0; exp_we = 0; exp_done = 0; exp_addr = '0; exp_wdata = '0;
    rq_cyc.delete(); rq_data.delete();
    g_ld = 0; g_fwd = 0; g_upd = 0;
  endtask

  // One clock cycle: entered just after a negedge with inputs driven, leaves at the next negedge.
  task automatic cycle();
    bit rd_exp;
    #1;
    g_ld = !m_run && bus.ld_req;
    g_fwd = 0; g_upd = 0;
    if (m_run) begin
      if (bus.fwd_req && bus.upd_req) begin
        g_fwd = m_rr_upd; g_upd = !m_rr_upd;
      end else begin
        g_fwd = bus.fwd_req; g_upd = bus.upd_req;
      end
    end
    chk("ld_gnt", DATA_W'(bus.ld_gnt), DATA_W'(g_ld));
    chk("fwd_gnt", DATA_W'(bus.fwd_gnt), DATA_W'(g_fwd));
    chk("upd_gnt", DATA_W'(bus.upd_gnt), DATA_W'(g_upd));
    chk("mem_en", DATA_W'(bus.mem_en), DATA_W'(exp_en));
    chk("mem_we", DATA_W'(bus.mem_we), DATA_W'(exp_we));
    chk("mem_addr", DATA_W'(bus.mem_addr), DATA_W'(exp_addr));
    chk("mem_wr_data", bus.mem_wr_data, exp_wdata);
    chk("running", DATA_W'(bus.running), DATA_W'(m_run));
    chk("load_done", DATA_W'(bus.load_done), DATA_W'(exp_done));
    rd_exp = (rq_cyc.size() > 0) && (rq_cyc[0] == cyc);
    chk("fwd_rd_vld", DATA_W'(bus.fwd_rd_vld), DATA_W'(rd_exp));
    if (rd_exp) begin
      chk("fwd_rd_data", bus.fwd_rd_data, rq_data[0]);
      void'(rq_cyc.pop_front());
      void'(rq_data.pop_front());
    end

    @(posedge clk);
    cyc++;
    exp_en = g_ld || g_fwd || g_upd;
    exp_we = g_ld || g_upd;
    exp_done = 0;
    if (g_ld) begin
      exp_addr = ADDR_W'(m_cnt); exp_wdata = bus.ld_data; shadow[m_cnt] = bus.ld_data;
      if (m_cnt == DEPTH - 1) begin m_run = 1; m_cnt = 0; exp_done = 1; end
      else m_cnt++;
    end
    if (g_upd) begin
      exp_addr = bus.upd_addr; exp_wdata = bus.upd_data; shadow[bus.upd_addr] = bus.upd_data;
      m_rr_upd = 1;
    end
    if (g_fwd) begin
      exp_addr = bus.fwd_addr;
      rq_cyc.push_back(cyc + RD_LAT);
      rq_data.push_back(shadow[bus.fwd_addr]);
      m_rr_upd = 0;
    end
    if (bus.reload) begin m_run = 0; m_cnt = 0; exp_done = 0; end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.reload = 0; bus.ld_req = 0; bus.fwd_req = 0; bus.upd_req = 0;
  endtask

  // Asynchronous reset in mid-cycle; registered outputs must clear at once.
  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    chk("rst_mem_en", DATA_W'(bus.mem_en), '0);
    chk("rst_mem_we", DATA_W'(bus.mem_we), '0);
    chk("rst_mem_addr", DATA_W'(bus.mem_addr), '0);
    chk("rst_mem_wr_data", bus.mem_wr_data, '0);
    chk("rst_fwd_rd_vld", DATA_W'(bus.fwd_rd_vld), '0);
    chk("rst_load_done", DATA_W'(bus.load_done), '0);
    chk("rst_running", DATA_W'(bus.running), '0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_words(input int n, input bit reload_last);
    for (int i = 0; i < n; i++) begin
      bus.ld_req = 1; bus.ld_data = DATA_W'(i + 32'h100 * (cyc & 255));
      bus.reload = reload_last && (i == n - 1);
      cycle();
    end
    bus.ld_req = 0; bus.reload = 0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; shadow[i] = '0; end
    reset = 1'b1;
    bus.ld_data = '0; bus.fwd_addr = '0; bus.upd_addr = '0; bus.upd_data = '0;
    idle_inputs();
    do_reset();

    // Initial load with fwd_req held off.
    bus.fwd_req = 1; bus.fwd_addr = 4'd1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.ld_req = 1; bus.ld_data = DATA_W'(i);
      cycle();
    end
    idle_inputs();
    cycle();

    // Contention alternates fwd/upd starting with fwd.
    for (int i = 0; i < 6; i++) begin
      bus.fwd_req = 1; bus.upd_req = 1;
      if (g_fwd || i == 0) bus.fwd_addr = ADDR_W'($urandom);
      if (g_upd || i == 0) begin bus.upd_addr = ADDR_W'($urandom); bus.upd_data = rnd_word(); end
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();

    // Back-to-back reads at 3, 7, 9.
    bus.fwd_req = 1;
    bus.fwd_addr = 4'd3; cycle();
    bus.fwd_addr = 4'd7; cycle();
    bus.fwd_addr = 4'd9; cycle();
    idle_inputs();
    repeat (5) cycle();

    // Reload in RUN with a read in flight, then load from address 0.
    bus.fwd_req = 1; bus.fwd_addr = 4'd5; cycle();
    bus.fwd_req = 0; bus.reload = 1; cycle();
    bus.reload = 0;
    load_words(3, 0);
    repeat (2) cycle();

    // Reload coincident with the final load grant, then full load.
    bus.reload = 1; cycle(); bus.reload = 0;
    load_words(DEPTH, 1);
    repeat (2) cycle();
    load_words(DEPTH, 0);
    repeat (2) cycle();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      if (!bus.ld_req || g_ld) begin bus.ld_req = 1'($urandom); bus.ld_data = rnd_word(); end
      if (!bus.fwd_req || g_fwd) begin bus.fwd_req = 1'($urandom); bus.fwd_addr = ADDR_W'($urandom); end
      if (!bus.upd_req || g_upd) begin
        bus.upd_req = 1'($urandom); bus.upd_addr = ADDR_W'($urandom); bus.upd_data = rnd_word();
      end
      bus.reload = ($urandom_range(0, 59) == 0);
      cycle();
    end
    idle_inputs();
    repeat (RD_LAT + 2) cycle();

    // Reset with a read pending; it must never return.
    if (!m_run) load_words(DEPTH - m_cnt, 0);
    cycle();
    bus.fwd_req = 1; bus.fwd_addr = 4'd2; cycle();
    bus.fwd_req = 0; cycle();
    do_reset();
    repeat (RD_LAT + 4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
